// File: rtl/param_iram_loader.sv
// Instruction RAM for the fetch path: self-clears after reset, then takes a program over a byte-wide loader port.
// Define IRAM_PARITY_EN to store an even-parity bit per word and flag parity errors on fetch via PERR.
`timescale 1ns/1ps
module param_iram_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [ADDR_WIDTH-1:0]    ADDR,
    input  logic                     RD_EN,
    output logic [DATA_WIDTH-1:0]    Q,
    output logic                     Q_VALID,
    output logic                     MISALIGN,
    input  logic                     LD_START,
    input  logic [7:0]               LD_DATA,
    input  logic                     LD_VALID,
    input  logic                     LD_LAST,
    output logic                     LD_READY,
    output logic                     LD_OVF,
    output logic [$clog2(DEPTH):0]   WORDS_LOADED,
    output logic                     BUSY,
    output logic                     PERR
);
    // state | meaning
    // CLEAR | wiping mem[ptr] to zero, one word per cycle
    // IDLE  | serving fetches, waiting for LD_START
    // LOAD  | assembling loader bytes into words at mem[ptr]

    localparam int BPW    = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(BPW);
    localparam int LANE_W = (BPW > 1) ? OFF : 1;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int EXT_W  = (ADDR_WIDTH > PTR_W) ? ADDR_WIDTH : PTR_W;
`ifdef IRAM_PARITY_EN
    localparam int MEM_W  = DATA_WIDTH + 1;
`else
    localparam int MEM_W  = DATA_WIDTH;
`endif
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [PTR_W-1:0]       ptr, ptr_next;
    logic [LANE_W-1:0]      lane, lane_next;
    logic [DATA_WIDTH-1:0]  word_buf, buf_next, asm_word;
    logic [PTR_W-1:0]       wl_next;
    logic                   ovf_next;

    logic                   mem_we;
    logic [IDX_W-1:0]       mem_waddr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic [MEM_W-1:0]       mem_wfull;
    logic [MEM_W-1:0]       mem [DEPTH];

    logic [EXT_W-1:0]       fetch_idx;
    logic                   in_range;
    logic                   misalign;
    logic [MEM_W-1:0]       rd_word;
    logic                   fetch;

    assign LD_READY = (state == S_LOAD);
    assign BUSY     = (state != S_IDLE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= S_CLEAR;
            ptr          <= '0;
            lane         <= '0;
            word_buf     <= '0;
            WORDS_LOADED <= '0;
            LD_OVF       <= 1'b0;
        end else begin
            state        <= state_next;
            ptr          <= ptr_next;
            lane         <= lane_next;
            word_buf     <= buf_next;
            WORDS_LOADED <= wl_next;
            LD_OVF       <= ovf_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        lane_next  = lane;
        buf_next   = word_buf;
        wl_next    = WORDS_LOADED;
        ovf_next   = LD_OVF;
        mem_we     = 1'b0;
        mem_waddr  = ptr[IDX_W-1:0];
        mem_wdata  = '0;
        asm_word   = word_buf;
        asm_word[8*int'(lane) +: 8] = LD_DATA;

        case (state)
            S_CLEAR: begin
                mem_we   = 1'b1;
                ptr_next = ptr + 1'b1;
                if (ptr == PTR_W'(DEPTH - 1)) begin
                    state_next = S_IDLE;
                    ptr_next   = '0;
                end
            end
            S_IDLE: begin
                if (LD_START) begin
                    state_next = S_LOAD;
                    ptr_next   = '0;
                    lane_next  = '0;
                    buf_next   = '0;
                    wl_next    = '0;
                    ovf_next   = 1'b0;
                end
            end
            S_LOAD: begin
                if (LD_VALID) begin
                    if (lane == LAST_LANE || LD_LAST) begin
                        // buffer restarts at zero so a short final word has clean upper lanes
                        lane_next = '0;
                        buf_next  = '0;
                        if (ptr == PTR_W'(DEPTH)) begin
                            ovf_next = 1'b1;
                        end else begin
                            mem_we    = 1'b1;
                            mem_wdata = asm_word;
                            ptr_next  = ptr + 1'b1;
                            wl_next   = WORDS_LOADED + 1'b1;
                        end
                        if (LD_LAST) state_next = S_IDLE;
                    end else begin
                        lane_next = lane + 1'b1;
                        buf_next  = asm_word;
                    end
                end
            end
            default: state_next = S_CLEAR;
        endcase
    end

`ifdef IRAM_PARITY_EN
    assign mem_wfull = {^mem_wdata, mem_wdata};
`else
    assign mem_wfull = mem_wdata;
`endif

    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_waddr] <= mem_wfull;
    end

    assign fetch_idx = EXT_W'(ADDR) >> OFF;
    assign in_range  = (fetch_idx < EXT_W'(DEPTH));
    assign misalign  = ((ADDR & ADDR_WIDTH'(BPW - 1)) != '0);
    assign rd_word   = mem[fetch_idx[IDX_W-1:0]];
    assign fetch     = (state == S_IDLE) && RD_EN;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Q        <= '0;
            Q_VALID  <= 1'b0;
            MISALIGN <= 1'b0;
        end else begin
            Q_VALID <= fetch;
            if (fetch) begin
                Q        <= in_range ? rd_word[DATA_WIDTH-1:0] : '0;
                MISALIGN <= misalign;
            end
        end
    end

`ifdef IRAM_PARITY_EN
    logic perr_q;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) perr_q <= 1'b0;
        else        perr_q <= fetch && in_range && ((^rd_word[DATA_WIDTH-1:0]) != rd_word[DATA_WIDTH]);
    end
    assign PERR = perr_q;
`else
    assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_param_iram_loader.sv
// Directed and randomized bench for param_iram_loader against a word-array model built from the loader byte rules.
`timescale 1ns/1ps
module tb_param_iram_loader;
    localparam int DW    = 16;
    localparam int DEPTH = 128;
    localparam int AW    = 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic [AW-1:0] ADDR = '0;
    logic          RD_EN = 1'b0;
    logic [DW-1:0] Q;
    logic          Q_VALID, MISALIGN;
    logic          LD_START = 1'b0;
    logic [7:0]    LD_DATA = '0;
    logic          LD_VALID = 1'b0;
    logic          LD_LAST = 1'b0;
    logic          LD_READY, LD_OVF, BUSY, PERR;
    logic [7:0]    WORDS_LOADED;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] model_mem [DEPTH];
    int          m_wl;
    logic        m_ovf;
    logic [7:0]  prog [$];

    param_iram_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .RD_EN(RD_EN), .Q(Q), .Q_VALID(Q_VALID),
        .MISALIGN(MISALIGN), .LD_START(LD_START), .LD_DATA(LD_DATA), .LD_VALID(LD_VALID),
        .LD_LAST(LD_LAST), .LD_READY(LD_READY), .LD_OVF(LD_OVF), .WORDS_LOADED(WORDS_LOADED),
        .BUSY(BUSY), .PERR(PERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Program image as little-endian 16-bit words, zero-padded, truncated at DEPTH words.
    function automatic void model_load();
        int n;
        int nw;
        n  = prog.size();
        nw = (n + 1) / 2;
        for (int w = 0; w < nw; w++) begin
            logic [7:0] lo, hi;
            lo = prog[2*w];
            hi = (2*w + 1 < n) ? prog[2*w + 1] : 8'h00;
            if (w < DEPTH) model_mem[w] = {hi, lo};
        end
        m_wl  = (nw > DEPTH) ? DEPTH : nw;
        m_ovf = (nw > DEPTH);
    endfunction

    task automatic fetch_exp(input logic [7:0] a, input logic [15:0] exp);
        ADDR  = a;
        RD_EN = 1'b1;
        @(negedge CLK);
        RD_EN = 1'b0;
        chk($sformatf("q@%02h", a), 32'(Q), 32'(exp));
        chk($sformatf("q_valid@%02h", a), 32'(Q_VALID), 32'(1));
        chk($sformatf("misalign@%02h", a), 32'(MISALIGN), 32'(a[0]));
        chk($sformatf("perr@%02h", a), 32'(PERR), 32'(0));
    endtask

    task automatic fetch_chk(input logic [7:0] a);
        fetch_exp(a, model_mem[a[7:1]]);
    endtask

    task automatic busy_count();
        int cnt;
        cnt = 0;
        while (BUSY === 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge CLK);
        end
        chk("busy_cycles", 32'(cnt), 32'(DEPTH));
        for (int w = 0; w < DEPTH; w++) model_mem[w] = 16'h0000;
    endtask

    // Loads prog[], firing a fetch at fa in the same cycle as LD_START.
    task automatic load_prog(input logic [7:0] fa);
        logic [15:0] e;
        int          wait_cnt;
        e = model_mem[fa[7:1]];
        ADDR     = fa;
        RD_EN    = 1'b1;
        LD_START = 1'b1;
        @(negedge CLK);
        RD_EN    = 1'b0;
        LD_START = 1'b0;
        chk("start_fetch_q", 32'(Q), 32'(e));
        chk("start_fetch_valid", 32'(Q_VALID), 32'(1));
        chk("start_busy", 32'(BUSY), 32'(1));
        chk("start_ready", 32'(LD_READY), 32'(1));
        chk("start_wl", 32'(WORDS_LOADED), 32'(0));
        chk("start_ovf", 32'(LD_OVF), 32'(0));
        for (int i = 0; i < prog.size(); i++) begin
            while ($urandom_range(0, 3) == 0) begin
                LD_VALID = 1'b0;
                LD_LAST  = 1'($urandom_range(0, 1));
                LD_DATA  = 8'($urandom);
                RD_EN    = 1'($urandom_range(0, 1));
                @(negedge CLK);
                chk("gap_q_valid", 32'(Q_VALID), 32'(0));
            end
            wait_cnt = 0;
            while (LD_READY !== 1'b1 && wait_cnt < 20) begin
                @(negedge CLK);
                wait_cnt++;
            end
            if (LD_READY !== 1'b1) chk("ld_ready_wait", 32'(LD_READY), 32'(1));
            LD_DATA  = prog[i];
            LD_VALID = 1'b1;
            LD_LAST  = (i == prog.size() - 1);
            RD_EN    = (i == prog.size() - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge CLK);
            if (Q_VALID !== 1'b0) chk("load_q_valid", 32'(Q_VALID), 32'(0));
        end
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
        RD_EN    = 1'b0;
        model_load();
        chk("end_wl", 32'(WORDS_LOADED), 32'(m_wl));
        chk("end_ovf", 32'(LD_OVF), 32'(m_ovf));
        chk("end_ready", 32'(LD_READY), 32'(0));
        chk("end_busy", 32'(BUSY), 32'(0));
    endtask

    initial begin
        for (int w = 0; w < DEPTH; w++) model_mem[w] = 16'h0000;

        #1;
        chk("rst_q", 32'(Q), 32'(0));
        chk("rst_q_valid", 32'(Q_VALID), 32'(0));
        chk("rst_misalign", 32'(MISALIGN), 32'(0));
        chk("rst_ready", 32'(LD_READY), 32'(0));
        chk("rst_ovf", 32'(LD_OVF), 32'(0));
        chk("rst_wl", 32'(WORDS_LOADED), 32'(0));
        chk("rst_busy", 32'(BUSY), 32'(1));
        chk("rst_perr", 32'(PERR), 32'(0));
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        busy_count();

        fetch_exp(8'h00, 16'h0000);
        fetch_exp(8'hFE, 16'h0000);
        @(negedge CLK);
        chk("hold_q_valid", 32'(Q_VALID), 32'(0));

        prog = '{8'h91, 8'hF4, 8'h49, 8'hF2};
        load_prog(8'h10);
        chk("tp_wl2", 32'(WORDS_LOADED), 32'(2));
        fetch_exp(8'h00, 16'hF491);
        fetch_exp(8'h02, 16'hF249);
        fetch_exp(8'h03, 16'hF249);
        @(negedge CLK);
        chk("hold_q", 32'(Q), 32'(16'hF249));
        chk("hold_valid", 32'(Q_VALID), 32'(0));

        prog = '{8'h11, 8'h22, 8'h33};
        load_prog(8'h02);
        chk("tp_partial_wl", 32'(WORDS_LOADED), 32'(2));
        fetch_exp(8'h02, 16'h0033);
        fetch_exp(8'h00, 16'h2211);

        for (int r = 0; r < 3; r++) begin
            int len;
            len = $urandom_range(1, 40);
            prog.delete();
            for (int i = 0; i < len; i++) prog.push_back(8'($urandom));
            load_prog(8'($urandom));
            for (int k = 0; k < 20; k++) fetch_chk(8'($urandom));
        end

        prog.delete();
        for (int i = 0; i < 260; i++) prog.push_back(8'($urandom));
        load_prog(8'($urandom));
        chk("ovf_flag", 32'(LD_OVF), 32'(1));
        chk("ovf_wl", 32'(WORDS_LOADED), 32'(DEPTH));
        fetch_exp(8'hFE, {prog[255], prog[254]});
        for (int w = 0; w < DEPTH; w++) fetch_chk(8'(2*w));

        prog = '{8'hA5, 8'h5A};
        load_prog(8'h01);
        chk("ovf_cleared", 32'(LD_OVF), 32'(0));

        LD_START = 1'b1;
        @(negedge CLK);
        LD_START = 1'b0;
        for (int i = 0; i < 5; i++) begin
            LD_DATA  = 8'($urandom);
            LD_VALID = 1'b1;
            @(negedge CLK);
        end
        LD_VALID = 1'b0;
        chk("midload_wl", 32'(WORDS_LOADED), 32'(2));
        RESET = 1'b0;
        #1;
        chk("midrst_busy", 32'(BUSY), 32'(1));
        chk("midrst_ready", 32'(LD_READY), 32'(0));
        chk("midrst_wl", 32'(WORDS_LOADED), 32'(0));
        chk("midrst_q", 32'(Q), 32'(0));
        @(negedge CLK);
        RESET = 1'b1;
        busy_count();
        chk("post_rst_ovf", 32'(LD_OVF), 32'(0));
        for (int w = 0; w < DEPTH; w++) fetch_exp(8'(2*w), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/param_iram_loader.md
Name: param_iram_loader

Overview:
- Parametrised instruction memory for the CPU fetch path.
- Programs are no longer hard-coded at reset. After reset the block clears the whole array itself, then accepts a program over a byte-wide valid/ready loader port.
- Serves registered fetches at byte addresses, with word-aligned indexing and misalignment flagging.
- Sits between the boot/loader source and the CPU instruction fetch stage.

Parameters:
- DATA_WIDTH, 16, instruction word width in bits; must be a multiple of 8. BPW = DATA_WIDTH/8 bytes per word.
- DEPTH, 128, number of words; power of two.
- ADDR_WIDTH, 8, width of the fetch byte address.

Ports:
- CLK  in  1  clock, all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- ADDR  in  ADDR_WIDTH  fetch byte address
- RD_EN  in  1  fetch request
- Q  out  DATA_WIDTH  fetched instruction word
- Q_VALID  out  1  Q valid, one cycle per accepted fetch
- MISALIGN  out  1  qualifies Q_VALID: ADDR low log2(BPW) bits were nonzero
- LD_START  in  1  pulse, opens a load session at word 0
- LD_DATA  in  8  loader byte
- LD_VALID  in  1  loader byte valid
- LD_LAST  in  1  final byte of session, qualified by LD_VALID
- LD_READY  out  1  block accepts loader bytes
- LD_OVF  out  1  sticky: bytes were dropped past DEPTH
- WORDS_LOADED  out  log2(DEPTH)+1  words written in current/last session
- BUSY  out  1  high in CLEAR or LOAD
- PERR  out  1  parity error on fetch (see optional feature)

Behaviour:
- Reset (RESET low, asynchronous):
  - State goes to CLEAR; clear pointer = 0.
  - Q = 0, Q_VALID = 0, MISALIGN = 0, LD_READY = 0, LD_OVF = 0, WORDS_LOADED = 0, BUSY = 1, PERR = 0.
  - The array itself is not async-reset.
- State CLEAR:
  - Writes 0 to mem[ptr] each cycle and increments ptr.
  - After writing word DEPTH-1, goes to IDLE.
  - Takes DEPTH cycles; BUSY falls on the first IDLE cycle.
  - RD_EN and LD_START are ignored.
- State IDLE:
  - Fetch: RD_EN=1 at edge N gives Q = mem[ADDR >> log2(BPW)] and Q_VALID=1 after edge N (1-cycle latency).
  - Q holds its value when there is no fetch; Q_VALID drops.
  - Word index >= DEPTH: Q = 0, Q_VALID = 1.
  - MISALIGN is registered alongside Q. A misaligned fetch still returns the truncated-index word.
  - LD_START=1: go to LOAD; write ptr = 0, byte lane = 0, WORDS_LOADED = 0, LD_OVF = 0.
  - RD_EN and LD_START in the same cycle: the fetch is served and the load begins.
- State LOAD:
  - LD_READY = 1 and BUSY = 1.
  - RD_EN is ignored (Q_VALID = 0). LD_START is ignored.
  - A byte is accepted on LD_VALID & LD_READY and stored little-endian: first byte to bits [7:0], lane k to bits [8k+7:8k].
  - When lane BPW-1 is filled, the word is written to mem[wptr]; wptr and WORDS_LOADED increment and the lane returns to 0.
  - Accepted byte with LD_LAST=1:
    - A partial word is written with unfilled lanes = 0.
    - A complete word is written normally.
    - State then goes to IDLE; LD_READY = 0 from the next cycle.
  - wptr == DEPTH: the word is dropped, LD_OVF = 1 (sticky until the next LD_START), WORDS_LOADED saturates at DEPTH.
- Reset mid-LOAD or mid-CLEAR: returns to CLEAR and the array is wiped again.
- The array has a single write port. CLEAR and LOAD writes never coincide because their states are exclusive.

Optional Feature:
- IRAM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, computed on every CLEAR/LOAD write.
  - On a fetch, PERR is registered alongside Q_VALID and goes high when the recomputed parity mismatches.
  - Out-of-range fetches give PERR = 0.
- Undefined: no parity storage; PERR tied to 0.

Test Plan:
- Reset, then wait: BUSY=1 for exactly 128 cycles. Then fetch ADDR=0x00 and 0xFE → Q=0x0000, Q_VALID=1, MISALIGN=0.
- Load bytes 0x91,0xF4,0x49,0xF2 (LD_LAST on the 4th) → WORDS_LOADED=2. ADDR=0x00 gives Q=0xF491; ADDR=0x02 gives Q=0xF249.
- Fetch ADDR=0x03 after the previous load → Q=0xF249, MISALIGN=1.
- Load 3 bytes 0x11,0x22,0x33 with LD_LAST on 0x33 → mem[1]=0x0033, WORDS_LOADED=2, state IDLE.
- Load 130 words (260 bytes) → LD_OVF=1, WORDS_LOADED=128, mem[127] holds the 128th word. The next LD_START clears LD_OVF.
- Assert RESET low mid-load after 5 bytes → BUSY stays high for 128 cycles. Every address then reads 0 and LD_OVF=0.
